pipe_ctrl: RTL and testbench

- Central pipeline hazard and exception controller for the 5-stage MIPS core.
- Produces the stall[5:0] vector consumed by PC, IF_ID, ID_EX, EX_MEM and MEM_WB. Each pipeline register holds when its bit is Stop; it inserts a bubble when its bit is Stop and the next bit is NoStop.
- Counts EX multi-cycle operations (mult/div) so the EX stage only issues one start pulse.
- Sequences exception and eret flush, and supplies the redirect PC.

---
 rtl/pipe_ctrl_pkg.sv | 33 +++
 rtl/pipe_mc_counter.sv | 49 ++++
 rtl/pipe_ctrl.sv | 117 +++++++++++
 tb/tb_pipe_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/exception controller:
// stall encodings, FSM state codes and default redirect constants.
package pipe_ctrl_pkg;

    localparam logic STOP       = 1'b1;
    localparam logic NO_STOP    = 1'b0;
    localparam logic RST_ENABLE = 1'b1;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0020;
    localparam logic [31:0] DEF_ERET_CODE  = 32'h0000_000E;
    localparam int unsigned DEF_MC_LEN_W   = 6;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_MC    = 2'd1,
        S_FLUSH = 2'd2
    } state_e;

    // Highest-priority request wins; each level stops every earlier stage too.
    function automatic logic [5:0] stall_sel(input logic mem_req, input logic ex_req,
                                             input logic id_req);
        if (mem_req)     return STALL_MEM;
        else if (ex_req) return STALL_EX;
        else if (id_req) return STALL_ID;
        else             return STALL_NONE;
    endfunction

endpackage

// File: rtl/pipe_mc_counter.sv
// Multi-cycle EX occupancy counter: loads len-1 on start, counts down while MEM
// is not stalling, and drives the registered busy flag.
module pipe_mc_counter
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MC_LEN_W = DEF_MC_LEN_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear_i,
    input  logic                load_i,
    input  logic [MC_LEN_W-1:0] len_i,
    input  logic                hold_i,
    output logic [MC_LEN_W-1:0] cnt_o,
    output logic                busy_o
);

    logic [MC_LEN_W-1:0] cnt_q, cnt_d;
    logic                busy_q, busy_d;

    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (clear_i) begin
            cnt_d  = '0;
            busy_d = 1'b0;
        end else if (load_i) begin
            cnt_d  = len_i - MC_LEN_W'(1);
            busy_d = 1'b1;
        end else if (busy_q && !hold_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - MC_LEN_W'(1);
            if (cnt_q == MC_LEN_W'(1)) busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign busy_o = busy_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller for the 5-stage core. Define
// PIPE_CTRL_PERF_CNT_EN to add saturating stall-cycle and flush counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR,
    parameter logic [31:0] ERET_CODE  = DEF_ERET_CODE,
    parameter int unsigned MC_LEN_W   = DEF_MC_LEN_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stallreq_id,
    input  logic                stallreq_ex,
    input  logic                stallreq_mem,
    input  logic                ex_mc_start,
    input  logic [MC_LEN_W-1:0] ex_mc_len,
    input  logic [31:0]         excptype_i,
    input  logic [31:0]         epc_i,
    output logic [5:0]          stall,
    output logic                flush,
    output logic [31:0]         new_pc,
    output logic                mc_busy
`ifdef PIPE_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]         perf_stall_cyc,
    output logic [15:0]         perf_flush_cnt
`endif
);

    state_e              state_q, state_d;
    logic                exc, mc_go, mc_load, mc_clear;
    logic [MC_LEN_W-1:0] mc_cnt;
    logic [31:0]         redirect_pc;

    assign exc         = (excptype_i != 32'h0);
    assign redirect_pc = (excptype_i == ERET_CODE) ? epc_i : EXC_VECTOR;
    assign mc_go       = ex_mc_start && (ex_mc_len >= MC_LEN_W'(2));

    always_comb begin
        stall    = STALL_NONE;
        flush    = 1'b0;
        new_pc   = 32'h0;
        state_d  = state_q;
        mc_load  = 1'b0;
        mc_clear = 1'b0;
        if (rst != RST_ENABLE) begin
            unique case (state_q)
                S_RUN: begin
                    if (exc) begin
                        flush    = 1'b1;
                        new_pc   = redirect_pc;
                        mc_clear = 1'b1;
                        state_d  = S_FLUSH;
                    end else begin
                        stall = stall_sel(stallreq_mem, stallreq_ex || mc_go, stallreq_id);
                        if (mc_go) begin
                            mc_load = 1'b1;
                            state_d = S_MC;
                        end
                    end
                end
                S_MC: begin
                    if (exc) begin
                        flush    = 1'b1;
                        new_pc   = redirect_pc;
                        mc_clear = 1'b1;
                        state_d  = S_FLUSH;
                    end else begin
                        stall = stall_sel(stallreq_mem, 1'b1, stallreq_id);
                        if (!stallreq_mem && (mc_cnt == MC_LEN_W'(1))) state_d = S_RUN;
                    end
                end
                S_FLUSH: state_d = S_RUN;
                default: state_d = S_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) state_q <= S_RUN;
        else                   state_q <= state_d;
    end

    pipe_mc_counter #(
        .MC_LEN_W (MC_LEN_W)
    ) u_mc_counter (
        .clk     (clk),
        .rst     (rst),
        .clear_i (mc_clear),
        .load_i  (mc_load),
        .len_i   (ex_mc_len),
        .hold_i  (stallreq_mem),
        .cnt_o   (mc_cnt),
        .busy_o  (mc_busy)
    );

`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [31:0] perf_stall_q;
    logic [15:0] perf_flush_q;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (stall[0] == STOP && perf_stall_q != '1) perf_stall_q <= perf_stall_q + 32'd1;
            if (flush && perf_flush_q != '1)            perf_flush_q <= perf_flush_q + 16'd1;
        end
    end

    assign perf_stall_cyc = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl: stall priority, multi-cycle
// hold with MEM freeze, exception/eret flush sequencing and reset.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_id, stallreq_ex, stallreq_mem, ex_mc_start;
    logic [5:0]  ex_mc_len;
    logic [31:0] excptype_i, epc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        mc_busy;
`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [31:0] perf_stall_cyc;
    logic [15:0] perf_flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .ex_mc_start  (ex_mc_start),
        .ex_mc_len    (ex_mc_len),
        .excptype_i   (excptype_i),
        .epc_i        (epc_i),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .mc_busy      (mc_busy)
`ifdef PIPE_CTRL_PERF_CNT_EN
        ,
        .perf_stall_cyc (perf_stall_cyc),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, where new inputs are driven.
    task automatic cyc();
        @(posedge clk);
        #1;
        stallreq_id  = 1'b0;
        stallreq_ex  = 1'b0;
        stallreq_mem = 1'b0;
        ex_mc_start  = 1'b0;
        ex_mc_len    = 6'd0;
        excptype_i   = 32'h0;
    endtask

    task automatic settle();
        #1;
    endtask

    logic [5:0] exp4 [6];

    initial begin
        rst = 1'b1; epc_i = 32'h0;
        cyc();
        // Outputs stay quiet under reset even with active requests.
        stallreq_mem = 1'b1; excptype_i = 32'h8; settle();
        chk("rst_stall", 32'(stall), 32'(STALL_NONE));
        chk("rst_flush", 32'(flush), 32'h0);
        chk("rst_newpc", new_pc, 32'h0);
        cyc();
        rst = 1'b0; settle();
        chk("rst_busy", 32'(mc_busy), 32'h0);
        chk("idle_stall", 32'(stall), 32'(6'b000000));

        // Load-use hazard for one cycle.
        cyc(); stallreq_id = 1'b1; settle();
        chk("id_stall", 32'(stall), 32'(6'b000111));
        cyc(); settle();
        chk("id_release", 32'(stall), 32'(6'b000000));

        // Priority: mem > ex > id.
        cyc(); stallreq_mem = 1'b1; stallreq_ex = 1'b1; stallreq_id = 1'b1; settle();
        chk("prio_mem", 32'(stall), 32'(6'b011111));
        stallreq_mem = 1'b0; settle();
        chk("prio_ex", 32'(stall), 32'(6'b001111));

        // Multi-cycle len=5: five hold cycles, busy on cycles 2..5.
        cyc(); ex_mc_start = 1'b1; ex_mc_len = 6'd5; settle();
        chk("mc5_c1_stall", 32'(stall), 32'(6'b001111));
        chk("mc5_c1_busy", 32'(mc_busy), 32'h0);
        for (int i = 2; i <= 5; i++) begin
            cyc();
            if (i == 3) begin
                ex_mc_start = 1'b1; ex_mc_len = 6'd20;  // ignored while busy
            end
            settle();
            chk($sformatf("mc5_c%0d_stall", i), 32'(stall), 32'(6'b001111));
            chk($sformatf("mc5_c%0d_busy", i), 32'(mc_busy), 32'h1);
        end
        cyc(); settle();
        chk("mc5_end_stall", 32'(stall), 32'(6'b000000));
        chk("mc5_end_busy", 32'(mc_busy), 32'h0);

        // len=1 and len=0 are single-cycle: no counter stall.
        cyc(); ex_mc_start = 1'b1; ex_mc_len = 6'd1; settle();
        chk("mc1_stall", 32'(stall), 32'(6'b000000));
        cyc(); ex_mc_start = 1'b1; ex_mc_len = 6'd0; settle();
        chk("mc0_stall", 32'(stall), 32'(6'b000000));
        chk("mc1_busy", 32'(mc_busy), 32'h0);
        cyc(); settle();
        chk("mc0_busy", 32'(mc_busy), 32'h0);

        // len=4 with MEM stalling in cycles 2 and 3: six hold cycles.
        exp4[0] = 6'b001111; exp4[1] = 6'b011111; exp4[2] = 6'b011111;
        exp4[3] = 6'b001111; exp4[4] = 6'b001111; exp4[5] = 6'b001111;
        cyc(); ex_mc_start = 1'b1; ex_mc_len = 6'd4; settle();
        chk("mc4_c1", 32'(stall), 32'(exp4[0]));
        for (int i = 1; i < 6; i++) begin
            cyc();
            stallreq_mem = (i == 1 || i == 2);
            settle();
            chk($sformatf("mc4_c%0d", i + 1), 32'(stall), 32'(exp4[i]));
            chk($sformatf("mc4_busy%0d", i + 1), 32'(mc_busy), 32'h1);
        end
        cyc(); settle();
        chk("mc4_end_stall", 32'(stall), 32'(6'b000000));
        chk("mc4_end_busy", 32'(mc_busy), 32'h0);

        // Exception in S_RUN beats a MEM stall, then one S_FLUSH cycle.
        cyc(); excptype_i = 32'h8; stallreq_mem = 1'b1; settle();
        chk("exc_flush", 32'(flush), 32'h1);
        chk("exc_newpc", new_pc, 32'h0000_0020);
        chk("exc_stall", 32'(stall), 32'(6'b000000));
        cyc(); excptype_i = 32'h8; stallreq_mem = 1'b1; settle();
        chk("sflush_flush", 32'(flush), 32'h0);
        chk("sflush_stall", 32'(stall), 32'(6'b000000));
        cyc(); stallreq_id = 1'b1; settle();
        chk("after_flush_run", 32'(stall), 32'(6'b000111));

        // eret during S_MC (len=10, three cycles in) redirects to EPC.
        cyc(); ex_mc_start = 1'b1; ex_mc_len = 6'd10; settle();
        cyc(); settle();
        cyc(); settle();
        chk("eret_pre_busy", 32'(mc_busy), 32'h1);
        cyc(); excptype_i = DEF_ERET_CODE; epc_i = 32'hBFC0_0100; settle();
        chk("eret_flush", 32'(flush), 32'h1);
        chk("eret_newpc", new_pc, 32'hBFC0_0100);
        chk("eret_stall", 32'(stall), 32'(6'b000000));
        cyc(); settle();
        chk("eret_busy_clr", 32'(mc_busy), 32'h0);
        chk("eret_sflush", 32'(flush), 32'h0);
        cyc(); stallreq_id = 1'b1; settle();
        chk("eret_back_run", 32'(stall), 32'(6'b000111));

        // Reset asserted mid-S_MC.
        cyc(); ex_mc_start = 1'b1; ex_mc_len = 6'd10; settle();
        cyc(); settle();
        chk("rstmc_busy", 32'(mc_busy), 32'h1);
        rst = 1'b1; excptype_i = 32'h8; stallreq_mem = 1'b1; settle();
        chk("rstmc_stall", 32'(stall), 32'(6'b000000));
        chk("rstmc_flush", 32'(flush), 32'h0);
        chk("rstmc_newpc", new_pc, 32'h0);
        cyc(); rst = 1'b0; settle();
        chk("rstmc_busy_clr", 32'(mc_busy), 32'h0);
        stallreq_id = 1'b1; settle();
        chk("rstmc_run", 32'(stall), 32'(6'b000111));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
